// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte handshake between the UART receiver and the bus
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 UART receiver with divider-driven 16x oversampling, 3-sample majority vote and 1-deep output buffer
module uart_rx_oversampled #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx,
  output logic                 busy,
  uart_rx_if.master            bus
);
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = OVERSAMPLE / 2 - 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [CW-1:0]          s_cnt_q, s_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d, data_q, data_d;
  logic                   pend_q, pend_d, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                   rx_s, tick, wrap, vote, stop_vote, load;
  // input sync, tick divider, votes and output buffer handshake
  always_comb begin
    rx_s      = sync_q[SYNC_STAGES-1];
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    // >= rather than == so a lowered baud_div never strands the counter above it
    tick      = div_q >= baud_div;
    div_d     = tick ? '0 : div_q + 1'b1;
    wrap      = tick && (s_cnt_q == CW'(OVERSAMPLE - 1));
    vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    // mid-stop decides on the third sample tick itself, so the live rx_s is the third vote
    stop_vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    load      = pend_q && (!valid_q || bus.rx_ready);
    data_d    = load ? shreg_q : data_q;
    valid_d   = load || (valid_q && !bus.rx_ready);
    ovr_d     = pend_q && valid_q && !bus.rx_ready;
  end
  // frame FSM: next state, oversample position, mid-bit samples and shift register
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    smp_d     = smp_q;
    shreg_d   = shreg_q;
    pend_d    = 1'b0;
    ferr_d    = 1'b0;
    if (tick) begin
      s_cnt_d = wrap ? '0 : s_cnt_q + 1'b1;
      for (int k = 0; k < 3; k++)
        if (s_cnt_q == CW'(MID + k)) smp_d[k] = rx_s;
      case (state_q)
        IDLE: begin
          s_cnt_d = '0;
          if (!rx_s) state_d = START;
        end
        START: if (wrap) begin
          state_d   = vote ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: if (wrap) begin
          shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
        end
        STOP: if (s_cnt_q == CW'(MID + 2)) begin
          state_d = IDLE;
          pend_d  = stop_vote;
          ferr_d  = !stop_vote;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // datapath registers; synchronizer resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      div_q     <= '0;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      smp_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      div_q     <= div_d;
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      smp_q     <= smp_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
endmodule
